// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Byte-oriented UART transmitter with a small input FIFO. Bytes pushed on
// tx_data/tx_wr are queued and sent on tx as 8N1 frames (start bit, 8 data
// bits LSB first, stop bit) at CLKS_PER_BIT clock cycles per bit. Frames are
// sent back to back with no idle gap while the FIFO has data.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (2..65535)
//   FIFO_DEPTH    FIFO entries (power of two, >= 2)
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   tx_data[7:0]  byte to enqueue, sampled when tx_wr = 1
//   tx_wr         push strobe, one byte per cycle high
//   tx            serial line, idles high, driven from a flop
//   tx_busy       high while a frame is on the line
//   tx_done_tick  one-cycle pulse in the last cycle of each stop bit
//   fifo_full     FIFO holds FIFO_DEPTH bytes
//   fifo_empty    FIFO holds no bytes
//   fifo_level    current byte count
//   ovf_tick      one-cycle pulse the cycle after a push was dropped
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 2622,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_wr,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          tx_done_tick,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ovf_tick
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [15:0]   BAUD_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0]   BAUD_PRE   = 16'(CLKS_PER_BIT - 2);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     baud_q, baud_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   count_q, count_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            pop_s;
    logic            push_s;
    logic            drop_s;
    logic            bit_end_s;

    // Transmit FSM: next state, baud/bit counters, shifter load/shift, pop request.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop_s     = 1'b0;
        bit_end_s = (baud_q == BAUD_LAST);

        case (state_q)
            S_IDLE: begin
                baud_d    = 16'd0;
                bit_idx_d = 3'd0;
                if (!empty_q) begin
                    pop_s   = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    baud_d    = 16'd0;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    baud_d  = 16'd0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end_s) begin
                    baud_d    = 16'd0;
                    bit_idx_d = 3'd0;
                    // Chain straight into the next frame when data is waiting.
                    if (!empty_q) begin
                        pop_s   = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                baud_d    = 16'd0;
                bit_idx_d = 3'd0;
            end
        endcase
    end

    // FIFO bookkeeping and registered status/line outputs.
    always_comb begin
        // Full is judged on the registered flag, so a pop in the same cycle
        // never makes room for a push that arrived while full.
        push_s   = tx_wr & ~full_q;
        drop_s   = tx_wr & full_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + LEVEL_ONE;
            2'b01:   count_d = count_q - LEVEL_ONE;
            default: count_d = count_q;
        endcase

        full_d  = (count_d == LEVEL_FULL);
        empty_d = (count_d == '0);

        // Line level follows the state being entered so tx is a pure flop output.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != S_IDLE);
        // Armed one cycle early so the registered pulse lands on the last stop cycle.
        done_d = (state_q == S_STOP) && (baud_q == BAUD_PRE);
        ovf_d  = drop_s;
    end

    // State, counter, FIFO pointer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            baud_q    <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
        end
    end

    // FIFO storage; contents are don't-care until the pointers reference them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    assign tx           = tx_q;
    assign tx_busy      = busy_q;
    assign tx_done_tick = done_q;
    assign fifo_full    = full_q;
    assign fifo_empty   = empty_q;
    assign fifo_level   = count_q;
    assign ovf_tick     = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Directed bench for uart_tx_fifo with CLKS_PER_BIT = 4, FIFO_DEPTH = 4.
// Pushed bytes go into an expected-byte queue; a line monitor decodes each
// 8N1 frame from tx and compares it against the head of that queue.
// Outputs are sampled on the falling clock edge; inputs change there too.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int C = 4;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_wr = 1'b0;
    logic       tx;
    logic       tx_busy;
    logic       tx_done_tick;
    logic       fifo_full;
    logic       fifo_empty;
    logic [2:0] fifo_level;
    logic       ovf_tick;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q [$];

    int         mon_cnt = 0;
    bit         mon_act = 1'b0;
    logic [7:0] mon_byte = 8'h00;
    int         frames_done = 0;
    int         ovf_seen = 0;

    uart_tx_fifo #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_data      (tx_data),
        .tx_wr        (tx_wr),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .fifo_level   (fifo_level),
        .ovf_tick     (ovf_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected line level at offset rel from the start of a frame carrying b.
    function automatic logic exp_line(input int rel, input logic [7:0] b);
        if (rel < 0) return 1'b1;
        if (rel < C) return 1'b0;
        if (rel < 9 * C) return b[(rel - C) / C];
        return 1'b1;
    endfunction

    task automatic wait_drained(input string tag);
        int n;
        n = 0;
        while (!(tx_busy === 1'b0 && fifo_empty === 1'b1) && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_no_timeout"}, 32'(n < 600), 32'd1);
        chk({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Line monitor: decodes frames mid-bit and scores them against exp_q.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_act = 1'b0;
            mon_cnt = 0;
        end else begin
            if (ovf_tick === 1'b1) ovf_seen++;
            if (!mon_act) begin
                if (tx === 1'b0) begin
                    mon_act = 1'b1;
                    mon_cnt = 0;
                end
            end else begin
                mon_cnt++;
                for (int i = 0; i < 8; i++) begin
                    if (mon_cnt == C * (1 + i) + C / 2) mon_byte[i] = tx;
                end
                if (mon_cnt == 10 * C - C / 2) begin
                    chk("stop_bit_high", 32'(tx), 32'd1);
                    chk("frame_was_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        chk("frame_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
                    end
                    frames_done++;
                    mon_act = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int viol;
        int first_start;
        int nd;
        int done_k [2];
        logic tx_log [0:99];
        logic busy_log [0:99];
        int frames_before;
        int n;
        bit found;

        // ---- reset and idle ----
        rst_n = 1'b0;
        tx_wr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_done", 32'(tx_done_tick), 32'd0);
        chk("rst_ovf", 32'(ovf_tick), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        rst_n = 1'b1;
        viol = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || fifo_empty !== 1'b1 || fifo_level !== 3'd0 || tx_busy !== 1'b0) viol++;
        end
        chk("idle_hold_violations", 32'(viol), 32'd0);

        // ---- single frame 0x55, push at k=0, start bit at k=2 ----
        @(negedge clk);
        tx_wr = 1'b1;
        tx_data = 8'h55;
        exp_q.push_back(8'h55);
        for (int k = 1; k <= 44; k++) begin
            @(negedge clk);
            tx_wr = 1'b0;
            chk($sformatf("single_tx_k%0d", k), 32'(tx), 32'(exp_line(k - 2, 8'h55)));
            chk($sformatf("single_busy_k%0d", k), 32'(tx_busy), 32'(k >= 2 && k < 2 + 10 * C));
            chk($sformatf("single_done_k%0d", k), 32'(tx_done_tick), 32'(k == 1 + 10 * C));
            if (k <= 3) begin
                chk($sformatf("single_empty_k%0d", k), 32'(fifo_empty), 32'(k != 1));
                chk($sformatf("single_level_k%0d", k), 32'(fifo_level), 32'(k == 1));
            end
        end
        wait_drained("single");

        // ---- back-to-back 0xA3, 0x0F ----
        @(negedge clk);
        tx_wr = 1'b1;
        tx_data = 8'hA3;
        exp_q.push_back(8'hA3);
        @(negedge clk);
        tx_data = 8'h0F;
        exp_q.push_back(8'h0F);
        first_start = -1;
        nd = 0;
        done_k[0] = 0;
        done_k[1] = 0;
        for (int k = 2; k <= 95; k++) begin
            @(negedge clk);
            tx_wr = 1'b0;
            tx_log[k] = tx;
            busy_log[k] = tx_busy;
            if (first_start < 0 && tx === 1'b0) first_start = k;
            if (tx_done_tick === 1'b1) begin
                if (nd < 2) done_k[nd] = k;
                nd++;
            end
        end
        chk("b2b_done_count", 32'(nd), 32'd2);
        chk("b2b_first_start", 32'(first_start), 32'd2);
        chk("b2b_second_start_tx", 32'(tx_log[done_k[0] + 1]), 32'd0);
        chk("b2b_busy_across", 32'(busy_log[done_k[0] + 1]), 32'd1);
        chk("b2b_total_cycles", 32'(done_k[1] - first_start + 1), 32'd80);
        chk("b2b_busy_falls", 32'(busy_log[done_k[1] + 1]), 32'd0);
        wait_drained("b2b");

        // ---- overflow: 6 pushes into depth-4 FIFO from idle ----
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 5) begin
                chk("ovf_full_set", 32'(fifo_full), 32'd1);
                chk("ovf_level_four", 32'(fifo_level), 32'd4);
                chk("ovf_busy", 32'(tx_busy), 32'd1);
                chk("ovf_tick_before", 32'(ovf_tick), 32'd0);
            end
            tx_wr = 1'b1;
            tx_data = 8'(8'h11 * (i + 1));
            if (i < 5) exp_q.push_back(8'(8'h11 * (i + 1)));
        end
        @(negedge clk);
        tx_wr = 1'b0;
        chk("ovf_tick_pulse", 32'(ovf_tick), 32'd1);
        @(negedge clk);
        chk("ovf_tick_after", 32'(ovf_tick), 32'd0);
        chk("ovf_level_held", 32'(fifo_level), 32'd4);
        chk("ovf_still_full", 32'(fifo_full), 32'd1);
        frames_before = frames_done;
        wait_drained("ovf");
        chk("ovf_frame_count", 32'(frames_done - frames_before), 32'd5);
        chk("ovf_pulse_count", 32'(ovf_seen), 32'd1);

        // ---- push during the STOP->START pop cycle ----
        @(negedge clk);
        tx_wr = 1'b1;
        tx_data = 8'h3C;
        exp_q.push_back(8'h3C);
        @(negedge clk);
        tx_data = 8'h81;
        exp_q.push_back(8'h81);
        @(negedge clk);
        tx_wr = 1'b0;
        n = 0;
        found = 1'b0;
        while (!found && n < 200) begin
            @(negedge clk);
            n++;
            if (tx_done_tick === 1'b1) found = 1'b1;
        end
        chk("pp_done_seen", 32'(found), 32'd1);
        chk("pp_level_before", 32'(fifo_level), 32'd1);
        tx_wr = 1'b1;
        tx_data = 8'hE7;
        exp_q.push_back(8'hE7);
        @(negedge clk);
        tx_wr = 1'b0;
        chk("pp_level_after", 32'(fifo_level), 32'd1);
        chk("pp_no_ovf", 32'(ovf_tick), 32'd0);
        chk("pp_next_start", 32'(tx), 32'd0);
        chk("pp_busy", 32'(tx_busy), 32'd1);
        wait_drained("pp");
        chk("pp_pulse_count", 32'(ovf_seen), 32'd1);

        // ---- reset during DATA bit 3 of 0xC6 ----
        @(negedge clk);
        tx_wr = 1'b1;
        tx_data = 8'hC6;
        exp_q.push_back(8'hC6);
        @(negedge clk);
        tx_wr = 1'b0;
        repeat (18) @(negedge clk);
        chk("rstmid_bit3_low", 32'(tx), 32'd0);
        chk("rstmid_busy_before", 32'(tx_busy), 32'd1);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("rstmid_tx_async", 32'(tx), 32'd1);
        chk("rstmid_busy_async", 32'(tx_busy), 32'd0);
        chk("rstmid_empty_async", 32'(fifo_empty), 32'd1);
        chk("rstmid_level_async", 32'(fifo_level), 32'd0);
        frames_before = frames_done;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        viol = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) viol++;
        end
        chk("rstmid_quiet_line", 32'(viol), 32'd0);
        chk("rstmid_empty_after", 32'(fifo_empty), 32'd1);
        chk("rstmid_no_frame", 32'(frames_done - frames_before), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
